// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks: default sizes, the
// result-store FSM state type and the ReLU helper.
package cnn_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 20;
    localparam int BLOCK_SIZE = 150;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } store_state_t;

    function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] word);
        return word[DATA_WIDTH-1] ? '0 : word;
    endfunction

endpackage

// File: rtl/result_store_if.sv
// Shared DMA write port: the store drives beats, the DMA answers with ready.
interface result_store_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 20
);
    logic                  dma_enable;
    logic                  dma_rw;
    logic [ADDR_WIDTH-1:0] dma_address;
    logic [DATA_WIDTH-1:0] dma_data;
    logic                  dma_ready;

    modport master (
        output dma_enable, dma_rw, dma_address, dma_data,
        input  dma_ready
    );

    modport slave (
        input  dma_enable, dma_rw, dma_address, dma_data,
        output dma_ready
    );
endinterface

// File: rtl/result_store.sv
// Snapshots one ALU output block and streams it to RAM over the shared DMA
// port, optionally applying ReLU, then pulses done for one cycle.
module result_store #(
    parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = cnn_pkg::ADDR_WIDTH,
    parameter int BLOCK_SIZE = cnn_pkg::BLOCK_SIZE,
    parameter int RELU_EN    = 0,
    localparam int CW        = $clog2(BLOCK_SIZE + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CW-1:0]         count,
    input  logic [DATA_WIDTH-1:0] result [0:BLOCK_SIZE-1],
    result_store_if.master        dma,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         words_written
);
    import cnn_pkg::*;

    store_state_t          state;
    logic [DATA_WIDTH-1:0] bufMem [0:BLOCK_SIZE-1];
    logic [ADDR_WIDTH-1:0] baseLatch;
    logic [CW-1:0]         countLatch;
    logic [CW-1:0]         index;
    logic [CW-1:0]         nextIndex;
    logic [CW-1:0]         clampedCount;
    logic                  lastBeat;
    logic                  dmaEnable;
    logic [ADDR_WIDTH-1:0] dmaAddress;
    logic [DATA_WIDTH-1:0] dmaData;

    function automatic logic [DATA_WIDTH-1:0] shapeWord(input logic [DATA_WIDTH-1:0] w);
        return ((RELU_EN != 0) && w[DATA_WIDTH-1]) ? '0 : w;
    endfunction

    assign clampedCount = (count > CW'(BLOCK_SIZE)) ? CW'(BLOCK_SIZE) : count;
    assign nextIndex    = index + CW'(1);
    assign lastBeat     = (index == countLatch - CW'(1));

    // Beat registers are loaded one edge ahead so address and data are
    // stable for the whole time the DMA holds off with ready low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            baseLatch     <= '0;
            countLatch    <= '0;
            index         <= '0;
            words_written <= '0;
            dmaEnable     <= 1'b0;
            dmaAddress    <= '0;
            dmaData       <= '0;
            done          <= 1'b0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                bufMem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (enable) begin
                        for (int i = 0; i < BLOCK_SIZE; i++) begin
                            bufMem[i] <= result[i];
                        end
                        baseLatch     <= base_addr;
                        countLatch    <= clampedCount;
                        index         <= '0;
                        words_written <= '0;
                        if (clampedCount == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= WRITE;
                            dmaEnable  <= 1'b1;
                            dmaAddress <= base_addr;
                            dmaData    <= shapeWord(result[0]);
                        end
                    end
                end
                WRITE: begin
                    if (dma.dma_ready) begin
                        index         <= nextIndex;
                        words_written <= words_written + CW'(1);
                        if (lastBeat) begin
                            state      <= DONE;
                            dmaEnable  <= 1'b0;
                            dmaAddress <= '0;
                            dmaData    <= '0;
                            done       <= 1'b1;
                        end else begin
                            dmaAddress <= baseLatch + ADDR_WIDTH'(nextIndex);
                            dmaData    <= shapeWord(bufMem[nextIndex]);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    dmaEnable <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    assign busy            = (state != IDLE);
    assign dma.dma_enable  = dmaEnable;
    assign dma.dma_rw      = 1'b0;
    assign dma.dma_address = dmaAddress;
    assign dma.dma_data    = dmaData;

endmodule

// File: tb/tb_result_store.sv
// Scoreboard bench for result_store: a plain and a ReLU instance share the
// same stimulus; a negedge monitor checks every accepted beat and done pulse.
module tb_result_store;

    localparam int DW = 16;
    localparam int AW = 20;
    localparam int BS = 150;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          dmaReady = 1'b1;
    logic [AW-1:0] baseAddr = '0;
    logic [CW-1:0] count = '0;
    logic [DW-1:0] result [0:BS-1];

    logic          busyP, doneP, busyR, doneR;
    logic [CW-1:0] wwP, wwR;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [AW+DW-1:0] beatQP[$];
    logic [AW+DW-1:0] beatQR[$];
    int               doneQP[$];
    int               doneQR[$];
    int               wwQP[$];
    int               wwQR[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    result_store_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busPlain ();
    result_store_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) busRelu ();

    assign busPlain.dma_ready = dmaReady;
    assign busRelu.dma_ready  = dmaReady;

    result_store #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .RELU_EN(0)) dutPlain (
        .clk(clk), .reset(reset), .enable(enable), .base_addr(baseAddr), .count(count),
        .result(result), .dma(busPlain.master), .busy(busyP), .done(doneP), .words_written(wwP)
    );

    result_store #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .RELU_EN(1)) dutRelu (
        .clk(clk), .reset(reset), .enable(enable), .base_addr(baseAddr), .count(count),
        .result(result), .dma(busRelu.master), .busy(busyR), .done(doneR), .words_written(wwR)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // One DUT's view of the scoreboard: beats pop the beat queue, done pops the done queue.
    task automatic monitorOne(input int d, input logic en, input logic rw, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data, input logic dn, input logic [CW-1:0] ww);
        logic [AW+DW-1:0] exp;
        int expCyc, expWw, qs;
        string tag;
        tag = (d == 0) ? "plain" : "relu";
        if (en) checkOutput({tag, " dma_rw"}, 64'(rw), 64'd0);
        if (en && dmaReady) begin
            qs = (d == 0) ? beatQP.size() : beatQR.size();
            if (qs == 0) begin
                checkOutput({tag, " unexpected beat"}, 64'(addr), 64'hFFFF_FFFF);
            end else begin
                exp = (d == 0) ? beatQP.pop_front() : beatQR.pop_front();
                checkOutput({tag, " beat addr"}, 64'(addr), 64'(exp[AW+DW-1:DW]));
                checkOutput({tag, " beat data"}, 64'(data), 64'(exp[DW-1:0]));
            end
        end
        if (dn) begin
            qs = (d == 0) ? doneQP.size() : doneQR.size();
            if (qs == 0) begin
                checkOutput({tag, " unexpected done"}, 64'd1, 64'd0);
            end else begin
                expCyc = (d == 0) ? doneQP.pop_front() : doneQR.pop_front();
                expWw  = (d == 0) ? wwQP.pop_front()   : wwQR.pop_front();
                checkOutput({tag, " done cycle"}, 64'(cyc), 64'(expCyc));
                checkOutput({tag, " words_written"}, 64'(ww), 64'(expWw));
            end
        end
    endtask

    always @(negedge clk) begin
        monitorOne(0, busPlain.dma_enable, busPlain.dma_rw, busPlain.dma_address, busPlain.dma_data, doneP, wwP);
        monitorOne(1, busRelu.dma_enable, busRelu.dma_rw, busRelu.dma_address, busRelu.dma_data, doneR, wwR);
    end

    function automatic logic [DW-1:0] reluModel(input logic [DW-1:0] w);
        return w[DW-1] ? 16'h0000 : w;
    endfunction

    task automatic pushBeat(input logic [AW-1:0] addr, input logic [DW-1:0] dPlain, input logic [DW-1:0] dRelu);
        beatQP.push_back({addr, dPlain});
        beatQR.push_back({addr, dRelu});
    endtask

    task automatic waitIdle(input string name);
        int t;
        t = 0;
        while ((busyP || busyR) && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (busyP || busyR) checkOutput({name, " idle timeout"}, 64'd1, 64'd0);
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, " plain outputs"},
                    64'({busPlain.dma_enable, busPlain.dma_rw, busPlain.dma_address, busPlain.dma_data, busyP, doneP, wwP}), 64'd0);
        checkOutput({name, " relu outputs"},
                    64'({busRelu.dma_enable, busRelu.dma_rw, busRelu.dma_address, busRelu.dma_data, busyR, doneR, wwR}), 64'd0);
    endtask

    // Starts one transfer; expected beats come from the freshly loaded result
    // array, and the array is scrambled right after capture.
    task automatic applyStimulus(input string name, input logic [AW-1:0] base, input int cnt,
                                 input int stallBeat, input int stallLen);
        int n;
        logic [AW-1:0] a;
        n = (cnt > BS) ? BS : cnt;
        waitIdle(name);
        @(posedge clk);
        #1;
        baseAddr = base;
        count    = CW'(cnt);
        enable   = 1'b1;
        for (int i = 0; i < n; i++) begin
            a = base + AW'(i);
            pushBeat(a, result[i], reluModel(result[i]));
        end
        doneQP.push_back(cyc + 1 + n + stallLen);
        doneQR.push_back(cyc + 1 + n + stallLen);
        wwQP.push_back(n);
        wwQR.push_back(n);
        @(posedge clk);
        #1;
        enable = 1'b0;
        for (int i = 0; i < BS; i++) result[i] = 16'hDEAD;
        if (stallLen > 0) begin
            repeat (stallBeat) begin
                @(posedge clk);
                #1;
            end
            dmaReady = 1'b0;
            for (int s = 0; s <= stallLen; s++) begin
                checkOutput({name, " stall hold addr"}, 64'(busPlain.dma_address), 64'(base + AW'(stallBeat)));
                checkOutput({name, " stall hold enable"}, 64'(busPlain.dma_enable), 64'd1);
                if (s < stallLen) begin
                    @(posedge clk);
                    #1;
                end
            end
            dmaReady = 1'b1;
        end
        waitIdle(name);
        checkOutput({name, " beats pending"}, 64'(beatQP.size() + beatQR.size()), 64'd0);
        checkOutput({name, " done pending"}, 64'(doneQP.size() + doneQR.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < BS; i++) result[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkResetOutputs("post reset idle");

        // Basic block: sign-bit patterns exercise ReLU on the second instance.
        result[0] = 16'h0001; result[1] = 16'h7FFF; result[2] = 16'h8000; result[3] = 16'hFFFF;
        applyStimulus("basic", 20'h00100, 4, 0, 0);

        // Two stalled edges on beat 1 stretch the transfer by two cycles.
        result[0] = 16'h0011; result[1] = 16'h0022; result[2] = 16'h0033;
        applyStimulus("stall", 20'h00400, 3, 1, 2);

        // Address wraps past the top of the DMA space.
        result[0] = 16'h1234; result[1] = 16'hFEDC; result[2] = 16'h0000; result[3] = 16'h8001;
        applyStimulus("wrap", 20'hFFFFE, 4, 0, 0);

        applyStimulus("count0", 20'h00500, 0, 0, 0);

        for (int i = 0; i < BS; i++) result[i] = 16'(i * 257);
        applyStimulus("clamp", 20'h01000, 200, 0, 0);

        // Reset lands while beat 2 of 10 is on the bus; only beats 0 and 1 complete.
        for (int i = 0; i < 10; i++) result[i] = 16'h0A00 + 16'(i);
        waitIdle("abort");
        @(posedge clk);
        #1;
        baseAddr = 20'h00200;
        count    = 8'd10;
        enable   = 1'b1;
        pushBeat(20'h00200, 16'h0A00, 16'h0A00);
        pushBeat(20'h00201, 16'h0A01, 16'h0A01);
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("abort beat2 addr", 64'(busPlain.dma_address), 64'h00202);
        #2;
        reset = 1'b0;
        #1;
        checkResetOutputs("abort async");
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkResetOutputs("abort held");
        checkOutput("abort beats pending", 64'(beatQP.size() + beatQR.size()), 64'd0);
        reset = 1'b1;

        result[0] = 16'h0B00; result[1] = 16'h8B01;
        applyStimulus("restart", 20'h00200, 2, 0, 0);

        repeat (3) @(posedge clk);
        checkOutput("final beats pending", 64'(beatQP.size() + beatQR.size()), 64'd0);
        checkOutput("final done pending", 64'(doneQP.size() + doneQR.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
